// File: rtl/mux_stim_gen.sv
// Stimulus generator driving a 2:1 mux stage with x/y/a vectors under a valid/ready handshake.
// Define MUX_STIM_LFSR_EN to replace the alternating y pattern with a 4-bit LFSR sequence.
module mux_stim_gen #(
   parameter int NUM_VEC = 12
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       out_ready,
   output logic       out_valid,
   output logic [3:0] x,
   output logic [3:0] y,
   output logic       a,
   output logic [7:0] vec_cnt,
   output logic       busy,
   output logic       done
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [7:0] LAST_CNT = (NUM_VEC == 0) ? 8'd0 : 8'(NUM_VEC - 1);

`ifdef MUX_STIM_LFSR_EN
   localparam logic [3:0] Y_SEED = 4'b0001;

   // x^4+x^3+1 Fibonacci LFSR, shifting left with feedback into bit 0
   function automatic logic [3:0] next_y(input logic [3:0] cur);
      return {cur[2:0], cur[3] ^ cur[2]};
   endfunction
`else
   localparam logic [3:0] Y_SEED = 4'd0;

   function automatic logic [3:0] next_y(input logic [3:0] cur);
      return 4'd15 - cur;
   endfunction
`endif

   state_t     state, state_nxt;
   logic [3:0] x_nxt, y_nxt;
   logic       a_nxt;
   logic [7:0] cnt_nxt;
   logic       valid_nxt;
   logic       busy_nxt;
   logic       done_nxt;
   logic       xfer;

   assign xfer = out_valid & out_ready;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         x         <= 4'd0;
         y         <= 4'd0;
         a         <= 1'b0;
         vec_cnt   <= 8'd0;
         out_valid <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         state     <= state_nxt;
         x         <= x_nxt;
         y         <= y_nxt;
         a         <= a_nxt;
         vec_cnt   <= cnt_nxt;
         out_valid <= valid_nxt;
         busy      <= busy_nxt;
         done      <= done_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      x_nxt     = x;
      y_nxt     = y;
      a_nxt     = a;
      cnt_nxt   = vec_cnt;
      valid_nxt = out_valid;

      case (state)
         IDLE: begin
            if (start) begin
               x_nxt   = 4'd0;
               y_nxt   = Y_SEED;
               a_nxt   = 1'b0;
               cnt_nxt = 8'd0;
               // An empty run still reports completion through DONE
               if (NUM_VEC == 0) begin
                  state_nxt = DONE;
                  valid_nxt = 1'b0;
               end else begin
                  state_nxt = RUN;
                  valid_nxt = 1'b1;
               end
            end
         end
         RUN: begin
            if (xfer) begin
               cnt_nxt = vec_cnt + 8'd1;
               if (vec_cnt == LAST_CNT) begin
                  state_nxt = DONE;
                  valid_nxt = 1'b0;
               end else begin
                  x_nxt = x + 4'd1;
                  y_nxt = next_y(y);
                  a_nxt = ~a;
               end
            end
         end
         DONE: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
            valid_nxt = 1'b0;
         end
      endcase

      // Status flags are registered copies of the state being entered
      busy_nxt = (state_nxt != IDLE);
      done_nxt = (state_nxt == DONE);
   end

endmodule

// File: tb/tb_mux_stim_gen.sv
// Bench for mux_stim_gen: three instances (12, 20 and 0 vectors) checked against a per-vector model.
module tb_mux_stim_gen;

   logic       clk;
   logic       reset;
   logic       out_ready;
   logic       start [3];
   logic       ov    [3];
   logic [3:0] xs    [3];
   logic [3:0] ys    [3];
   logic       as    [3];
   logic [7:0] cnt   [3];
   logic       bsy   [3];
   logic       dn    [3];

   int n_cmp = 0;
   int n_err = 0;

   mux_stim_gen #(.NUM_VEC(12)) u_dut12 (
      .clk(clk), .reset(reset), .start(start[0]), .out_ready(out_ready),
      .out_valid(ov[0]), .x(xs[0]), .y(ys[0]), .a(as[0]),
      .vec_cnt(cnt[0]), .busy(bsy[0]), .done(dn[0]));

   mux_stim_gen #(.NUM_VEC(20)) u_dut20 (
      .clk(clk), .reset(reset), .start(start[1]), .out_ready(out_ready),
      .out_valid(ov[1]), .x(xs[1]), .y(ys[1]), .a(as[1]),
      .vec_cnt(cnt[1]), .busy(bsy[1]), .done(dn[1]));

   mux_stim_gen #(.NUM_VEC(0)) u_dut0 (
      .clk(clk), .reset(reset), .start(start[2]), .out_ready(out_ready),
      .out_valid(ov[2]), .x(xs[2]), .y(ys[2]), .a(as[2]),
      .vec_cnt(cnt[2]), .busy(bsy[2]), .done(dn[2]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Reference: vector k of a run, derived from the run index alone
   function automatic logic [3:0] mdl_x(input int k);
      return 4'(k % 16);
   endfunction

   function automatic logic mdl_a(input int k);
      return 1'(k % 2);
   endfunction

   function automatic logic [3:0] mdl_y(input int k);
`ifdef MUX_STIM_LFSR_EN
      logic [3:0] seq [15] = '{1, 2, 4, 9, 3, 6, 13, 10, 5, 11, 7, 15, 14, 12, 8};
      return seq[k % 15];
`else
      return (k % 2 == 1) ? 4'd15 : 4'd0;
`endif
   endfunction

   task automatic check_idle(input int i, input string tag);
      chk({tag, "_valid"}, 32'(ov[i]),  0);
      chk({tag, "_busy"},  32'(bsy[i]), 0);
      chk({tag, "_done"},  32'(dn[i]),  0);
   endtask

   task automatic start_run(input int i, input bit keep);
      @(negedge clk);
      start[i] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      if (!keep) start[i] = 1'b0;
   endtask

   // mode 0: ready always high, 1: random ready, 2: stall 3 cycles at vector 4
   task automatic drive_run(input int i, input int n, input int mode, input int stop_at);
      int k = 0;
      int stall = 0;
      int cyc = 0;
      bit rdy;
      forever begin
         chk("run_valid", 32'(ov[i]),  1);
         chk("run_x",     32'(xs[i]),  32'(mdl_x(k)));
         chk("run_y",     32'(ys[i]),  32'(mdl_y(k)));
         chk("run_a",     32'(as[i]),  32'(mdl_a(k)));
         chk("run_cnt",   32'(cnt[i]), k);
         chk("run_busy",  32'(bsy[i]), 1);
         chk("run_done",  32'(dn[i]),  0);
         if (k == stop_at) return;
         case (mode)
            0: rdy = 1'b1;
            1: rdy = ($urandom_range(0, 3) != 0);
            default: begin
               rdy = !(k == 4 && stall < 3);
               if (k == 4 && !rdy) stall++;
            end
         endcase
         out_ready = rdy;
         @(posedge clk);
         @(negedge clk);
         if (rdy) k++;
         cyc++;
         if (k == n) break;
         if (cyc > 500) begin
            chk("run_timeout", 32'(cyc), 0);
            return;
         end
      end
      out_ready = 1'b0;
      chk("end_valid", 32'(ov[i]),  0);
      chk("end_done",  32'(dn[i]),  1);
      chk("end_busy",  32'(bsy[i]), 1);
      chk("end_cnt",   32'(cnt[i]), n);
      chk("end_x",     32'(xs[i]),  32'(mdl_x(n - 1)));
      chk("end_y",     32'(ys[i]),  32'(mdl_y(n - 1)));
      chk("end_a",     32'(as[i]),  32'(mdl_a(n - 1)));
      @(posedge clk);
      @(negedge clk);
      check_idle(i, "post");
      chk("post_cnt", 32'(cnt[i]), n);
   endtask

   initial begin
      reset = 1'b1;
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) start[i] = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         check_idle(i, "rst");
         chk("rst_x",   32'(xs[i]),  0);
         chk("rst_y",   32'(ys[i]),  0);
         chk("rst_a",   32'(as[i]),  0);
         chk("rst_cnt", 32'(cnt[i]), 0);
      end
      reset = 1'b0;

      // No start: block stays idle, ready ignored while invalid
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_idle(0, "nostart");
      out_ready = 1'b0;

      // Basic 12-vector run, ready constant
      start_run(0, 1'b0);
      drive_run(0, 12, 0, -1);

      // Stall for 3 cycles at x=4
      start_run(0, 1'b0);
      drive_run(0, 12, 2, -1);

      // Random backpressure
      for (int r = 0; r < 3; r++) begin
         start_run(0, 1'b0);
         drive_run(0, 12, 1, -1);
      end

      // 20 vectors: x wraps through 15 -> 0
      start_run(1, 1'b0);
      drive_run(1, 20, 0, -1);
      start_run(1, 1'b0);
      drive_run(1, 20, 1, -1);

      // Start held high: ignored in RUN/DONE, restarts from IDLE
      start_run(0, 1'b1);
      drive_run(0, 12, 0, -1);
      @(posedge clk);
      @(negedge clk);
      start[0] = 1'b0;
      drive_run(0, 12, 1, -1);

      // Asynchronous reset mid-run at vec_cnt=5
      start_run(0, 1'b0);
      drive_run(0, 12, 0, 5);
      out_ready = 1'b1;
      #2 reset = 1'b1;
      #1;
      check_idle(0, "arst");
      chk("arst_x",   32'(xs[0]),  0);
      chk("arst_y",   32'(ys[0]),  0);
      chk("arst_a",   32'(as[0]),  0);
      chk("arst_cnt", 32'(cnt[0]), 0);
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      out_ready = 1'b0;
      repeat (3) begin
         @(posedge clk);
         @(negedge clk);
         check_idle(0, "arst_wait");
      end
      start_run(0, 1'b0);
      drive_run(0, 12, 0, -1);

      // Empty run
      out_ready = 1'b1;
      start_run(2, 1'b0);
      chk("nv0_valid", 32'(ov[2]),  0);
      chk("nv0_done",  32'(dn[2]),  1);
      chk("nv0_busy",  32'(bsy[2]), 1);
      chk("nv0_cnt",   32'(cnt[2]), 0);
      @(posedge clk);
      @(negedge clk);
      check_idle(2, "nv0_post");
      chk("nv0_post_cnt", 32'(cnt[2]), 0);
      out_ready = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/mux_stim_gen.md
MUX_STIM_GEN -- requirements
Module: mux_stim_gen

Interface
REQ-001 Parameter: NUM_VEC, default 12, number of vectors issued per run (legal range 0..255).
REQ-002 Port: clk  input  1  single clock; all state updates on the rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-high reset.
REQ-004 Port: start  input  1  run request, sampled in IDLE only.
REQ-005 Port: out_ready  input  1  downstream (2:1 mux stage) accepts the current vector.
REQ-006 Port: out_valid  output  1  x/y/a hold a valid vector.
REQ-007 Port: x  output  4  operand X to mux stage.
REQ-008 Port: y  output  4  operand Y to mux stage.
REQ-009 Port: a  output  1  select A to mux stage.
REQ-010 Port: vec_cnt  output  8  number of vectors accepted in current run.
REQ-011 Port: busy  output  1  high when state is not IDLE.
REQ-012 Port: done  output  1  one-cycle pulse at end of run.

Function
REQ-013 FSM SHALL have exactly three states: IDLE, RUN, DONE; all outputs registered.
REQ-014 IDLE: start=1 at an edge SHALL load x=0, y=0, a=0, vec_cnt=0 and go to RUN with out_valid=1 (one cycle start-to-valid latency); if NUM_VEC=0, go to DONE instead with out_valid staying 0.
REQ-015 RUN: while out_valid=1 and out_ready=0, x, y, a, vec_cnt SHALL hold stable.
REQ-016 RUN: on edge with out_valid=1 and out_ready=1 (transfer), vec_cnt SHALL increment by 1.
REQ-017 Transfer with vec_cnt=NUM_VEC-1: SHALL go to DONE, drop out_valid to 0, leave x/y/a at last value.
REQ-018 Other transfers: next vector SHALL be a=~a, x=x+1 (mod 16, 15 wraps to 0), y=15-y; out_valid remains 1, so back-to-back transfers occur every cycle when out_ready=1.
REQ-019 DONE: done=1 for exactly one cycle, then IDLE unconditionally.
REQ-020 start SHALL be ignored in RUN and DONE; start held high in IDLE after a run begins a new run.
REQ-021 out_ready SHALL be ignored when out_valid=0.
REQ-022 busy SHALL be 1 in RUN and DONE, 0 in IDLE.

Reset
REQ-023 reset=1 SHALL immediately (no clock needed) force state=IDLE, x=0, y=0, a=0, vec_cnt=0, out_valid=0, busy=0, done=0.
REQ-024 Reset asserted mid-run SHALL abort the run with no done pulse; after release, block waits for start.

Configuration
REQ-025 Macro MUX_STIM_LFSR_EN defined: y SHALL be a 4-bit Fibonacci LFSR (x^4+x^3+1, shift left, feedback = y[3]^y[2]) seeded to 4'b0001 at start and advanced on each non-final transfer; all other behaviour unchanged.
REQ-026 Macro MUX_STIM_LFSR_EN undefined: y SHALL follow REQ-018 (0,15,0,15,...).

Verification
REQ-027 Reset, then start pulse, out_ready=1 constant, NUM_VEC=12 -> 12 consecutive valid cycles: x=0..11, a=0,1,0,..., y=0,15,0,...; vec_cnt=12; done pulse one cycle after last transfer; busy low after.
REQ-028 out_ready=0 for 3 cycles at vector x=4 -> x=4, y=0, a=0 held 4 cycles; run still ends with vec_cnt=12.
REQ-029 NUM_VEC=20, out_ready=1 -> x wraps 15->0 at vector 17; final x=3, y=15, a=1.
REQ-030 reset asserted at vec_cnt=5 -> all outputs 0 asynchronously, no done pulse; new start restarts at x=0.
REQ-031 NUM_VEC=0, start pulse -> out_valid never asserts; done pulse on second cycle after start; vec_cnt=0.
REQ-032 MUX_STIM_LFSR_EN defined, out_ready=1 -> y sequence 1,2,4,9,3,6,13,10,5,11,7,15.
